// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch, load/store) in front of a single-port memory.
// One transaction in flight at a time; data has priority, bounded by a starvation counter.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  // state  | meaning
  // IDLE   | arbitrating; request presented to memory combinationally
  // WAIT_I | fetch granted, waiting for mem_rvalid_i
  // WAIT_D | load/store granted, waiting for mem_rvalid_i
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_DATA_BURST);

  state_t     state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic       sel_data, sel_instr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      burst_q <= 4'd0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    burst_d        = burst_q;
    sel_data       = data_req_i && !(instr_req_i && (burst_q == BURST_LIMIT));
    sel_instr      = instr_req_i && !sel_data;
    instr_gnt_o    = 1'b0;
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    data_gnt_o     = 1'b0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_be_o       = '0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;

    // Outputs are forced quiet while reset is held, even though state only clears on the edge.
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          mem_req_o = sel_data || sel_instr;
          if (sel_data) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
          end else if (sel_instr) begin
            mem_be_o   = '1;
            mem_addr_o = instr_addr_i;
          end
          instr_gnt_o = mem_gnt_i && sel_instr;
          data_gnt_o  = mem_gnt_i && sel_data;

          if (instr_gnt_o) begin
            state_d = WAIT_I;
          end else if (data_gnt_o) begin
            state_d = WAIT_D;
          end

          if (instr_gnt_o || !instr_req_i) begin
            burst_d = 4'd0;
          end else if (data_gnt_o && (burst_q != BURST_LIMIT)) begin
            burst_d = burst_q + 4'd1;
          end
        end
        WAIT_I: begin
          if (mem_rvalid_i) begin
            instr_rvalid_o = 1'b1;
            instr_rdata_o  = mem_rdata_i;
            state_d        = IDLE;
          end
        end
        WAIT_D: begin
          if (mem_rvalid_i) begin
            data_rvalid_o = 1'b1;
            data_rdata_o  = mem_rdata_i;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
